// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: instruction field positions and a raw field decode helper.
// Used by the id_stage_pipe slice (optional write-through bypass: ID_BYPASS_EN).
package mips_pkg;

  localparam int INST_W  = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_W   = 16;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int REG_F_W = RS_MSB - RS_LSB + 1;

  // Raw instruction fields before they are narrowed to the register-file index width.
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [REG_F_W-1:0] rs;
    logic [REG_F_W-1:0] rt;
    logic [REG_F_W-1:0] rd;
    logic [IMM_W-1:0]   imm;
  } inst_fields_t;

  function automatic inst_fields_t decode_inst(input logic [INST_W-1:0] inst);
    inst_fields_t f;
    f.opcode = inst[OPC_MSB:OPC_LSB];
    f.rs     = inst[RS_MSB:RS_LSB];
    f.rt     = inst[RT_MSB:RT_LSB];
    f.rd     = inst[RD_MSB:RD_LSB];
    f.imm    = inst[IMM_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID + WB inputs and ID/EX outputs of the decode stage, bundled as one interface.
// master drives the stage (upstream/hazard/WB side), slave is the decode stage itself.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
);
  localparam int ADDR_W = $clog2(REG_N);

  logic [31:0]       inst_in;
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic              sign_ext;
  logic              reg_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] write_data;

  logic              valid_out;
  logic [5:0]        opcode_out;
  logic [ADDR_W-1:0] rs_out;
  logic [ADDR_W-1:0] rt_out;
  logic [ADDR_W-1:0] rd_out;
  logic [DATA_W-1:0] imm_out;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;

  modport master (
    output inst_in, valid_in, stall, flush, sign_ext, reg_write, wr_addr, write_data,
    input  valid_out, opcode_out, rs_out, rt_out, rd_out, imm_out, data_1, data_2
  );

  modport slave (
    input  inst_in, valid_in, stall, flush, sign_ext, reg_write, wr_addr, write_data,
    output valid_out, opcode_out, rs_out, rt_out, rd_out, imm_out, data_1, data_2
  );
endinterface

// File: rtl/mips_regfile.sv
// Register file: two combinational read ports, one synchronous write port, reg0 hardwired to 0.
// ID_BYPASS_EN makes a same-cycle write visible on the read ports (write-through).
module mips_regfile #(
  parameter int  DATA_W = 32,
  parameter int  REG_N  = 32,
  localparam int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [REG_N];

  // NOTE: the array is cleared on reset because the architecture requires all registers to
  // read 0 after reset; this forces flops rather than a RAM macro, which is fine at this size.
  // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

`ifdef ID_BYPASS_EN
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];
`else
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: field decode, immediate extension, operand read and the ID/EX pipeline register.
// Optional macro ID_BYPASS_EN enables WB->ID write-through inside the register file.
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input logic            clk,
  input logic            rst_n,
  id_stage_pipe_if.slave bus
);

  localparam int ADDR_W = $clog2(REG_N);

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] data_1;
    logic [DATA_W-1:0] data_2;
  } id_ex_t;

  inst_fields_t      fields;
  logic [ADDR_W-1:0] rs_idx;
  logic [ADDR_W-1:0] rt_idx;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  id_ex_t            id_ex_d;
  id_ex_t            id_ex_q;

  assign fields = decode_inst(bus.inst_in);
  assign rs_idx = fields.rs[ADDR_W-1:0];
  assign rt_idx = fields.rt[ADDR_W-1:0];

  // With a 16-bit datapath there are no upper bits to fill, so sign_ext is irrelevant.
  generate
    if (DATA_W == IMM_W) begin : g_imm_native
      assign imm_ext = fields.imm;
    end else begin : g_imm_extend
      assign imm_ext = bus.sign_ext ? {{(DATA_W-IMM_W){fields.imm[IMM_W-1]}}, fields.imm}
                                    : {{(DATA_W-IMM_W){1'b0}}, fields.imm};
    end
  endgenerate

  mips_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.reg_write),
    .wa    (bus.wr_addr),
    .wd    (bus.write_data),
    .ra1   (rs_idx),
    .ra2   (rt_idx),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // NOTE: the whole struct is assigned on every path, so no latch can be inferred.
  always_comb begin
    id_ex_d        = id_ex_q;
    id_ex_d.valid  = bus.valid_in;
    id_ex_d.opcode = fields.opcode;
    id_ex_d.rs     = rs_idx;
    id_ex_d.rt     = rt_idx;
    id_ex_d.rd     = fields.rd[ADDR_W-1:0];
    id_ex_d.imm    = imm_ext;
    id_ex_d.data_1 = rd1;
    id_ex_d.data_2 = rd2;
  end

  // Flush outranks stall: a killed slot must become a bubble even while EX is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else if (bus.flush) begin
      id_ex_q <= '0;
    end else if (!bus.stall) begin
      id_ex_q <= id_ex_d;
    end
  end

  assign bus.valid_out  = id_ex_q.valid;
  assign bus.opcode_out = id_ex_q.opcode;
  assign bus.rs_out     = id_ex_q.rs;
  assign bus.rt_out     = id_ex_q.rt;
  assign bus.rd_out     = id_ex_q.rd;
  assign bus.imm_out    = id_ex_q.imm;
  assign bus.data_1     = id_ex_q.data_1;
  assign bus.data_2     = id_ex_q.data_2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed cases plus randomized traffic against a
// register-array reference model; a second 64-bit/16-register instance covers the widened build.
module tb_id_stage_pipe;

  localparam int DW  = 32;
  localparam int RN  = 32;
  localparam int AW  = 5;
  localparam int DWB = 64;
  localparam int RNB = 16;
  localparam int AWB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DW),  .REG_N(RN))  bus  ();
  id_stage_pipe_if #(.DATA_W(DWB), .REG_N(RNB)) busb ();

  id_stage_pipe #(.DATA_W(DW),  .REG_N(RN))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  id_stage_pipe #(.DATA_W(DWB), .REG_N(RNB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(busb.slave));

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: architectural register contents and the expected ID/EX outputs.
  logic [DW-1:0] mem [RN];
  logic          e_valid;
  logic [5:0]    e_opc;
  logic [AW-1:0] e_rs, e_rt, e_rd;
  logic [DW-1:0] e_imm, e_d1, e_d2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input int opc, input int rs, input int rt,
                                          input int imm);
    logic [31:0] w;
    w[31:26] = 6'(opc);
    w[25:21] = 5'(rs);
    w[20:16] = 5'(rt);
    w[15:0]  = 16'(imm);
    return w;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic v, input logic st, input logic fl,
                       input logic se, input logic we, input int wa, input logic [DW-1:0] wd);
    bus.inst_in    = inst;
    bus.valid_in   = v;
    bus.stall      = st;
    bus.flush      = fl;
    bus.sign_ext   = se;
    bus.reg_write  = we;
    bus.wr_addr    = AW'(wa);
    bus.write_data = wd;
  endtask

  task automatic model_clear();
    for (int i = 0; i < RN; i++) mem[i] = '0;
    e_valid = 1'b0; e_opc = '0; e_rs = '0; e_rt = '0; e_rd = '0;
    e_imm = '0; e_d1 = '0; e_d2 = '0;
  endtask

  function automatic logic [DW-1:0] ref_read(input int idx);
    if (idx == 0) return '0;
`ifdef ID_BYPASS_EN
    if (bus.reg_write && int'(bus.wr_addr) == idx) return bus.write_data;
`endif
    return mem[idx];
  endfunction

  // Applies the ID/EX rules and the register write for the inputs currently driven.
  task automatic model_edge();
    int rs, rt;
    rs = int'(bus.inst_in[25:21]) % RN;
    rt = int'(bus.inst_in[20:16]) % RN;
    if (bus.flush) begin
      e_valid = 1'b0; e_opc = '0; e_rs = '0; e_rt = '0; e_rd = '0;
      e_imm = '0; e_d1 = '0; e_d2 = '0;
    end else if (!bus.stall) begin
      e_valid = bus.valid_in;
      e_opc   = bus.inst_in[31:26];
      e_rs    = AW'(rs);
      e_rt    = AW'(rt);
      e_rd    = AW'(int'(bus.inst_in[15:11]) % RN);
      e_imm   = bus.sign_ext ? DW'($signed(bus.inst_in[15:0])) : DW'(bus.inst_in[15:0]);
      e_d1    = ref_read(rs);
      e_d2    = ref_read(rt);
    end
    if (bus.reg_write && bus.wr_addr != '0) mem[bus.wr_addr] = bus.write_data;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  64'(bus.valid_out),  64'(e_valid));
    check({tag, ".opcode"}, 64'(bus.opcode_out), 64'(e_opc));
    check({tag, ".rs"},     64'(bus.rs_out),     64'(e_rs));
    check({tag, ".rt"},     64'(bus.rt_out),     64'(e_rt));
    check({tag, ".rd"},     64'(bus.rd_out),     64'(e_rd));
    check({tag, ".imm"},    64'(bus.imm_out),    64'(e_imm));
    check({tag, ".data_1"}, 64'(bus.data_1),     64'(e_d1));
    check({tag, ".data_2"}, 64'(bus.data_2),     64'(e_d2));
  endtask

  // One clock: model the edge, advance, then sample 1 time unit after posedge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},  64'(bus.valid_out),  64'd0);
    check({tag, ".opcode"}, 64'(bus.opcode_out), 64'd0);
    check({tag, ".rs"},     64'(bus.rs_out),     64'd0);
    check({tag, ".rt"},     64'(bus.rt_out),     64'd0);
    check({tag, ".rd"},     64'(bus.rd_out),     64'd0);
    check({tag, ".imm"},    64'(bus.imm_out),    64'd0);
    check({tag, ".data_1"}, 64'(bus.data_1),     64'd0);
    check({tag, ".data_2"}, 64'(bus.data_2),     64'd0);
  endtask

  initial begin
    logic [31:0] inst;
    int          wa;

    model_clear();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    busb.inst_in = '0; busb.valid_in = 1'b0; busb.stall = 1'b0; busb.flush = 1'b0;
    busb.sign_ext = 1'b0; busb.reg_write = 1'b0; busb.wr_addr = '0; busb.write_data = '0;

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write r5, then read it through rs with rt=0
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 32'hDEADBEEF);
    step("t2_write");
    drive(mk_inst(6'h23, 5, 0, 16'h0004), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    step("t2_read");
    check("t2_data_1", 64'(bus.data_1), 64'hDEADBEEF);
    check("t2_data_2", 64'(bus.data_2), 64'd0);
    check("t2_valid",  64'(bus.valid_out), 64'd1);

    // Same-cycle write and read of r7
    drive(mk_inst(6'h08, 7, 0, 16'h0010), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7, 32'h1234);
    step("t3_rw");
`ifdef ID_BYPASS_EN
    check("t3_data_1", 64'(bus.data_1), 64'h1234);
`else
    check("t3_data_1", 64'(bus.data_1), 64'h0);
`endif

    // Immediate extension of 0x8001
    drive(mk_inst(6'h09, 1, 2, 16'h8001), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0);
    step("t4_sext");
    check("t4_imm_sext", 64'(bus.imm_out), 64'hFFFF8001);
    drive(mk_inst(6'h0D, 1, 2, 16'h8001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    step("t4_zext");
    check("t4_imm_zext", 64'(bus.imm_out), 64'h00008001);

    // Two stall cycles (with a write to the source register), then flush with stall
    drive(mk_inst(6'h04, 5, 7, 16'h7FFF), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0);
    step("t5_load");
    drive(mk_inst(6'h3F, 9, 10, 16'hABCD), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5, 32'h55AA55AA);
    step("t5_stall1");
    check("t5_stall1_d1", 64'(bus.data_1), 64'hDEADBEEF);
    drive(mk_inst(6'h2B, 11, 12, 16'h1111), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    step("t5_stall2");
    check("t5_stall2_valid", 64'(bus.valid_out), 64'd1);
    drive(mk_inst(6'h2B, 5, 7, 16'h2222), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, '0);
    step("t5_flush");
    check_all_zero("t5_flush_zero");

    // Write to r0 is dropped
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'hFFFFFFFF);
    step("t6_write");
    drive(mk_inst(6'h00, 0, 0, 16'h0000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    step("t6_read");
    check("t6_data_1", 64'(bus.data_1), 64'd0);

    // 64-bit / 16-register instance: write r5, then read it
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    busb.reg_write = 1'b1; busb.wr_addr = AWB'(5); busb.write_data = 64'hDEADBEEF;
    step("b_write");
    busb.reg_write = 1'b0; busb.valid_in = 1'b1; busb.inst_in = mk_inst(6'h23, 5, 0, 16'h0004);
    step("b_read");
    check("b_data_1", 64'(busb.data_1), 64'hDEADBEEF);
    check("b_data_2", 64'(busb.data_2), 64'd0);
    check("b_valid",  64'(busb.valid_out), 64'd1);
    check("b_rs",     64'(busb.rs_out), 64'd5);
    busb.valid_in = 1'b0; busb.inst_in = '0;

    // Randomized traffic, biased so reads often hit the register being written
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      wa   = int'($urandom_range(0, RN - 1));
      if ($urandom_range(0, 2) == 0) inst[25:21] = 5'(wa);
      if ($urandom_range(0, 3) == 0) inst[20:16] = 5'(wa);
      drive(inst, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), wa, $urandom);
      step("rand");
    end

    // Reset mid-run while valid_out=1
    for (int i = 1; i < RN; i++) begin
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, i, $urandom | 32'h1);
      step("refill");
    end
    drive(mk_inst(6'h01, 5, 9, 16'h0101), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    step("pre_reset");
    check("pre_reset_valid", 64'(bus.valid_out), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk_inst(6'h01, 5, 9, 16'h0101), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    step("post_reset");
    check("post_reset_d1", 64'(bus.data_1), 64'd0);
    check("post_reset_d2", 64'(bus.data_2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
